// File: rtl/bus_grant_arbiter_pkg.sv
// Shared types and helpers for the i281 bus grant arbiter.
// Holds the requester count, index width, FSM state enum and the
// round-robin pick function used by the top-level arbiter.
package i281_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
  } pick_t;

  // Returns the first set request bit at or after 'start', wrapping 7->0.
  // The loop runs from the farthest offset down, so the nearest hit wins.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   start);
    pick_t            result;
    logic [IDX_W-1:0] idx;
    result = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = start + IDX_W'(i);
      if (req[idx]) begin
        result.found = 1'b1;
        result.index = idx;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bus_grant_arbiter_if.sv
// Request/grant bundle between the eight requesters and the arbiter.
// The master side drives requests and the owner release pulse; the
// slave side (the arbiter) drives the grant outputs.
interface bus_grant_arbiter_if;
  import i281_arb_pkg::*;

  logic [NUM_REQ-1:0] request;
  logic               owner_release;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_index;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               timeout_flag;

  modport master (
    output request,
    output owner_release,
    input  grant_valid,
    input  grant_index,
    input  grant_onehot,
    input  timeout_flag
  );

  modport slave (
    input  request,
    input  owner_release,
    output grant_valid,
    output grant_index,
    output grant_onehot,
    output timeout_flag
  );

endinterface

// File: rtl/bus_grant_arbiter_decoder.sv
// Existing i281 3-to-8 decoder with enable. The arbiter feeds it the
// registered owner index and valid bit so its one-hot output is the grant.
module _3to8DecoderWithEnable (
  input  logic       Enable,
  input  logic [2:0] Decoder_Input,
  output logic [7:0] Decoder_Output
);

  // One-hot decode of the select, forced to zero when disabled.
  always_comb begin
    Decoder_Output = '0;
    if (Enable) begin
      Decoder_Output[Decoder_Input] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin arbiter sharing one i281 bus slot among eight requesters.
// An owner keeps the bus until it releases or drops its request, then a
// one-cycle GAP separates it from the next grant. The previous owner has
// the lowest priority in the next search.
// Optional feature: define ARB_TIMEOUT_EN to bound each tenure to
// MAX_HOLD cycles and raise a sticky timeout flag on forced revocation.
module bus_grant_arbiter
  import i281_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_grant_arbiter_if.slave   bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_grant_arbiter: MAX_HOLD must be in 1..255");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             valid_q;
  pick_t            pick;
  logic             owner_holds;
  logic             hold_expired;

  assign pick        = rr_pick(bus.request, last_q + IDX_W'(1));
  assign owner_holds = bus.request[index_q] && !bus.owner_release;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             flag_q;
  logic             flag_set;

  assign hold_expired = (hold_q == CNT_W'(MAX_HOLD));
  assign flag_set     = (state_q == GRANT) && owner_holds && hold_expired;

  // Hold counter: 1 on the first GRANT cycle, cleared whenever not in GRANT.
  always_comb begin
    hold_d = '0;
    if (state_d == GRANT) begin
      hold_d = (state_q == GRANT) ? hold_q + CNT_W'(1) : CNT_W'(1);
    end
  end

  // Tenure counter and sticky forced-revocation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      flag_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      if (flag_set) begin
        flag_q <= 1'b1;
      end
    end
  end

  assign bus.timeout_flag = flag_q;
`else
  assign hold_expired     = 1'b0;
  assign bus.timeout_flag = 1'b0;
`endif

  // Next-state logic: arbitrate from IDLE or GAP, leave GRANT on release,
  // dropped request or hold expiry.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    last_d  = last_q;
    case (state_q)
      IDLE, GAP: begin
        if (pick.found) begin
          state_d = GRANT;
          index_d = pick.index;
          last_d  = pick.index;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!owner_holds || hold_expired) begin
          state_d = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, owner index, round-robin pointer and registered grant valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      index_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      index_q <= index_d;
      valid_q <= (state_d == GRANT);
    end
  end

  assign bus.grant_valid = valid_q;
  assign bus.grant_index = index_q;

  _3to8DecoderWithEnable u_decoder (
    .Enable         (valid_q),
    .Decoder_Input  (index_q),
    .Decoder_Output (bus.grant_onehot)
  );

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Self-checking bench for bus_grant_arbiter: directed scenarios plus a
// randomized run, all compared against a tenure-level reference model.
// Builds with or without ARB_TIMEOUT_EN (MAX_HOLD fixed at 4 here).
module tb_bus_grant_arbiter;
  import i281_arb_pkg::*;

  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  bus_grant_arbiter_if bus ();

  bus_grant_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: current owner (-1 when none), last winner, index shown
  // on the grant_index output, cycles held so far, sticky timeout.
  int mOwner, mLast, mShown, mHeld;
  bit mFlag;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mOwner = -1;
    mLast  = NUM_REQ - 1;
    mShown = 0;
    mHeld  = 0;
    mFlag  = 1'b0;
  endtask

  task automatic modelStep(input logic [7:0] req, input logic rel);
    int winner;
    if (mOwner >= 0) begin
      if (rel || !req[mOwner]) begin
        mOwner = -1;
        mHeld  = 0;
      end else if (TO_EN && mHeld == MAX_HOLD) begin
        mOwner = -1;
        mHeld  = 0;
        mFlag  = 1'b1;
      end else begin
        mHeld++;
      end
    end else begin
      winner = -1;
      for (int k = NUM_REQ; k >= 1; k--) begin
        if (req[(mLast + k) % NUM_REQ]) winner = (mLast + k) % NUM_REQ;
      end
      if (winner >= 0) begin
        mOwner = winner;
        mLast  = winner;
        mShown = winner;
        mHeld  = 1;
      end
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".valid"}, 32'(bus.grant_valid), 32'(mOwner >= 0));
    checkOutput({tag, ".index"}, 32'(bus.grant_index), 32'(mShown));
    checkOutput({tag, ".onehot"}, 32'(bus.grant_onehot),
                (mOwner >= 0) ? (32'd1 << mShown) : 32'd0);
    checkOutput({tag, ".tflag"}, 32'(bus.timeout_flag), 32'(mFlag));
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the
  // rising edge, then compare at the next falling edge.
  task automatic applyStimulus(input string tag, input logic [7:0] req,
                               input logic rel);
    bus.request       = req;
    bus.owner_release = rel;
    @(posedge clk);
    modelStep(req, rel);
    @(negedge clk);
    compareAll(tag);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst               = 1'b1;
    bus.request       = '0;
    bus.owner_release = 1'b0;
    #1;
    modelReset();
    compareAll("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int runLen;
    bit stillOn;
    logic [7:0] rreq;
    logic       rrel;

    rst               = 1'b1;
    bus.request       = '0;
    bus.owner_release = 1'b0;
    modelReset();
    #1;
    compareAll("por");
    @(negedge clk);
    rst = 1'b0;

    // Single request after reset.
    applyStimulus("single.idle", 8'h00, 1'b0);
    applyStimulus("single.req", 8'h10, 1'b0);
    checkOutput("single.idx4", 32'(bus.grant_index), 32'd4);
    checkOutput("single.oh", 32'(bus.grant_onehot), 32'h10);
    for (int i = 0; i < 3; i++) applyStimulus("single.hold", 8'h10, 1'b0);
    applyStimulus("single.rel", 8'h10, 1'b1);
    checkOutput("single.gap", 32'(bus.grant_valid), 32'd0);
    applyStimulus("single.idle2", 8'h00, 1'b0);
    checkOutput("single.back_idle", 32'(bus.grant_valid), 32'd0);

    // Fairness and wrap with all requesters active.
    doReset();
    applyStimulus("rr.first", 8'hFF, 1'b0);
    checkOutput("rr.order0", 32'(bus.grant_index), 32'd0);
    for (int t = 1; t <= 8; t++) begin
      applyStimulus("rr.rel", 8'hFF, 1'b1);
      checkOutput("rr.gap", 32'(bus.grant_valid), 32'd0);
      applyStimulus("rr.grant", 8'hFF, 1'b0);
      checkOutput("rr.order", 32'(bus.grant_index), 32'(t % 8));
    end

    // Owner drops its request without a release pulse.
    doReset();
    applyStimulus("drop.grant", 8'h04, 1'b0);
    applyStimulus("drop.hold", 8'h04, 1'b0);
    applyStimulus("drop.gap", 8'h81, 1'b0);
    checkOutput("drop.gapv", 32'(bus.grant_valid), 32'd0);
    applyStimulus("drop.g7", 8'h81, 1'b0);
    checkOutput("drop.idx7", 32'(bus.grant_index), 32'd7);
    applyStimulus("drop.rel", 8'h81, 1'b1);
    applyStimulus("drop.g0", 8'h81, 1'b0);
    checkOutput("drop.idx0", 32'(bus.grant_index), 32'd0);

    // Release and a new request in the same cycle; release while idle.
    doReset();
    applyStimulus("sim.g5", 8'h20, 1'b0);
    applyStimulus("sim.relreq", 8'h28, 1'b1);
    checkOutput("sim.gap", 32'(bus.grant_valid), 32'd0);
    applyStimulus("sim.g3", 8'h08, 1'b0);
    checkOutput("sim.idx3", 32'(bus.grant_index), 32'd3);
    applyStimulus("sim.rel3", 8'h08, 1'b1);
    applyStimulus("sim.idle", 8'h00, 1'b0);
    applyStimulus("sim.idlerel", 8'h00, 1'b1);
    checkOutput("sim.idlestay", 32'(bus.grant_valid), 32'd0);

    // Asynchronous reset in the middle of a tenure.
    doReset();
    applyStimulus("arst.g6", 8'h40, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst.valid", 32'(bus.grant_valid), 32'd0);
    checkOutput("arst.onehot", 32'(bus.grant_onehot), 32'd0);
    modelReset();
    compareAll("arst");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("arst.gC1", 8'hC1, 1'b0);
    checkOutput("arst.idx0", 32'(bus.grant_index), 32'd0);

    // Owner that never releases: bounded only with the timeout feature.
    doReset();
    applyStimulus("to.grant", 8'h02, 1'b0);
    runLen  = bus.grant_valid ? 1 : 0;
    stillOn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus("to.hold", 8'h02, 1'b0);
      if (bus.grant_valid && stillOn) runLen++;
      else stillOn = 1'b0;
    end
    checkOutput("to.tenure", 32'(runLen), TO_EN ? 32'd4 : 32'd7);
    checkOutput("to.flag", 32'(bus.timeout_flag), 32'(TO_EN));
    for (int i = 0; i < 3; i++) applyStimulus("to.more", 8'h02, 1'b0);

    // Randomized traffic against the reference model.
    doReset();
    rreq = 8'($urandom);
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < NUM_REQ; b++) begin
        if ($urandom_range(0, 7) == 0) rreq[b] = ~rreq[b];
      end
      rrel = ($urandom_range(0, 5) == 0);
      applyStimulus("rand", rreq, rrel);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
